// File: rtl/coin_credit_unit_pkg.sv
// coin_credit_unit_pkg: shared state enum, credit type, default coin/price tables and lowest-index select
package coin_credit_unit_pkg;
  localparam int DEF_CREDIT_W = 8;
  typedef logic [DEF_CREDIT_W-1:0] credit_t;
  typedef enum logic [1:0] {IDLE, CREDIT, REFUND} state_t;
  localparam logic [2*DEF_CREDIT_W-1:0] DEF_COIN_VALUES = {8'd20, 8'd2};
  localparam logic [2*DEF_CREDIT_W-1:0] DEF_PRICES = {8'd10, 8'd5};
  function automatic logic [31:0] first_one(input logic [31:0] v);
    return v & (~v + 32'd1);
  endfunction
endpackage

// File: rtl/coin_credit_unit_if.sv
// coin_credit_unit_if: selection-side bus; master drives accept_en/coin_in/buy_req/cancel, slave drives credit, session and vend/refund results
interface coin_credit_unit_if #(
  parameter int NUM_COINS = 2,
  parameter int NUM_GOODS = 2,
  parameter int CREDIT_W = 8
);
  logic accept_en;
  logic [NUM_COINS-1:0] coin_in;
  logic [NUM_GOODS-1:0] buy_req;
  logic cancel;
  logic [CREDIT_W-1:0] credit;
  logic session_active;
  logic [NUM_COINS-1:0] coin_reject;
  logic [NUM_GOODS-1:0] vend_ack;
  logic [NUM_GOODS-1:0] vend_nack;
  logic change_valid;
  logic [CREDIT_W-1:0] change_value;
  modport master (
    output accept_en, coin_in, buy_req, cancel,
    input credit, session_active, coin_reject, vend_ack, vend_nack, change_valid, change_value
  );
  modport slave (
    input accept_en, coin_in, buy_req, cancel,
    output credit, session_active, coin_reject, vend_ack, vend_nack, change_valid, change_value
  );
endinterface

// File: rtl/coin_credit_unit_edge_det_vec.sv
// edge_det_vec: registered history, rise = d & ~prev; ports clk, rst (async active-low), d, rise
module edge_det_vec #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] rise
);
  logic [W-1:0] prev;
  always_ff @(posedge clk or negedge rst)
    if (!rst) prev <= '0;
    else prev <= d;
  assign rise = d & ~prev;
endmodule

// File: rtl/coin_credit_unit.sv
// coin_credit_unit: saturating coin credit with vend/reject and cancel/timeout refund; ports clk, rst (async active-low), bus (slave); CHANGE_DISPENSE_EN selects serial change dispense
module coin_credit_unit
  import coin_credit_unit_pkg::*;
#(
  parameter int NUM_COINS = 2,
  parameter int NUM_GOODS = 2,
  parameter int CREDIT_W = DEF_CREDIT_W,
  parameter int MAX_CREDIT = 30,
  parameter logic [NUM_COINS*CREDIT_W-1:0] COIN_VALUES = DEF_COIN_VALUES,
  parameter logic [NUM_GOODS*CREDIT_W-1:0] PRICES = DEF_PRICES,
  parameter int TIMEOUT_CYC = 0
) (
  input logic clk,
  input logic rst,
  coin_credit_unit_if.slave bus
);
  localparam int TW = TIMEOUT_CYC > 0 ? $clog2(TIMEOUT_CYC + 1) : 1;
  state_t state, state_n;
  logic [CREDIT_W-1:0] credit, credit_n, cab, price, value, chg_val, chg_val_n;
  logic [CREDIT_W:0] sum;
  logic [NUM_COINS-1:0] coin_ev, coin_sel, coin_rej, coin_rej_n;
  logic [NUM_GOODS-1:0] buy_ev, buy_sel, ack, ack_n, nack, nack_n;
  logic cancel_ev, to_refund, refund_done, buy_ok, coin_ok, chg_v, chg_v_n;
  logic [TW-1:0] tmr, tmr_n;
  edge_det_vec #(.W(NUM_COINS)) u_coin (.clk(clk), .rst(rst), .d(bus.coin_in), .rise(coin_ev));
  edge_det_vec #(.W(NUM_GOODS)) u_buy (.clk(clk), .rst(rst), .d(bus.buy_req), .rise(buy_ev));
  edge_det_vec #(.W(1)) u_cancel (.clk(clk), .rst(rst), .d(bus.cancel), .rise(cancel_ev));
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      credit <= '0;
      tmr <= '0;
      coin_rej <= '0;
      ack <= '0;
      nack <= '0;
      chg_v <= 1'b0;
      chg_val <= '0;
    end else begin
      state <= state_n;
      credit <= credit_n;
      tmr <= tmr_n;
      coin_rej <= coin_rej_n;
      ack <= ack_n;
      nack <= nack_n;
      chg_v <= chg_v_n;
      chg_val <= chg_val_n;
    end
`ifdef CHANGE_DISPENSE_EN
  // chg_val doubles as the remaining-units counter while dispensing
  assign refund_done = chg_val <= CREDIT_W'(1);
`else
  assign refund_done = 1'b1;
`endif
  always_comb
    state_n = to_refund ? REFUND :
              state == REFUND ? (refund_done ? IDLE : REFUND) :
              (credit_n == '0 ? IDLE : CREDIT);
  always_comb begin
    price = '0;
    value = '0;
    buy_sel = NUM_GOODS'(first_one(32'(buy_ev)));
    coin_sel = NUM_COINS'(first_one(32'(coin_ev)));
    for (int i = 0; i < NUM_GOODS; i++) if (buy_sel[i]) price = PRICES[i*CREDIT_W +: CREDIT_W];
    for (int i = 0; i < NUM_COINS; i++) if (coin_sel[i]) value = COIN_VALUES[i*CREDIT_W +: CREDIT_W];
    // a cancel or timeout only acts in CREDIT and then blocks every buy/coin of that cycle
    to_refund = state == CREDIT && (cancel_ev || (TIMEOUT_CYC != 0 && tmr == TW'(TIMEOUT_CYC)));
    buy_ok = |buy_ev && !to_refund && bus.accept_en && state == CREDIT && credit >= price;
    cab = buy_ok ? credit - price : credit;
    sum = {1'b0, cab} + {1'b0, value};
    coin_ok = |coin_ev && !to_refund && bus.accept_en && state != REFUND && sum <= (CREDIT_W+1)'(MAX_CREDIT);
    credit_n = to_refund ? '0 : coin_ok ? sum[CREDIT_W-1:0] : cab;
    ack_n = buy_ok ? buy_sel : '0;
    nack_n = buy_ev & ~ack_n;
    coin_rej_n = coin_ev & ~(coin_ok ? coin_sel : '0);
    tmr_n = (|coin_ev || |buy_ev || cancel_ev || state_n != state || state != CREDIT) ? '0 : tmr + TW'(1);
`ifdef CHANGE_DISPENSE_EN
    chg_v_n = state == REFUND;
    chg_val_n = to_refund ? credit : state == REFUND ? chg_val - CREDIT_W'(1) : '0;
`else
    chg_v_n = to_refund;
    chg_val_n = to_refund ? credit : '0;
`endif
  end
  assign bus.credit = credit;
  assign bus.session_active = state == CREDIT && bus.accept_en;
  assign bus.coin_reject = coin_rej;
  assign bus.vend_ack = ack;
  assign bus.vend_nack = nack;
  assign bus.change_valid = chg_v;
  assign bus.change_value = chg_val;
endmodule

// File: tb/tb_coin_credit_unit.sv
// tb_coin_credit_unit: directed checks of credit, vend, reject, refund, timeout and reset behaviour
module tb_coin_credit_unit;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  coin_credit_unit_if #(.NUM_COINS(2), .NUM_GOODS(2), .CREDIT_W(8)) i1 ();
  coin_credit_unit_if #(.NUM_COINS(2), .NUM_GOODS(2), .CREDIT_W(8)) i2 ();
  coin_credit_unit u1 (.clk(clk), .rst(rst), .bus(i1));
  coin_credit_unit #(.TIMEOUT_CYC(100)) u2 (.clk(clk), .rst(rst), .bus(i2));
  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_chk++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
    end
  endtask
  task automatic drive(input logic [1:0] c, input logic [1:0] b, input logic x);
    i1.coin_in = c;
    i1.buy_req = b;
    i1.cancel = x;
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    drive(2'b00, 2'b00, 1'b0);
  endtask
  initial begin
    int n;
    i1.accept_en = 1'b1;
    i1.coin_in = '0;
    i1.buy_req = '0;
    i1.cancel = 1'b0;
    i2.accept_en = 1'b1;
    i2.coin_in = '0;
    i2.buy_req = '0;
    i2.cancel = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_credit", i1.credit, 0);
    chk("rst_session", i1.session_active, 0);
    chk("rst_chg_valid", i1.change_valid, 0);
    chk("rst_acks", {i1.vend_ack, i1.vend_nack, i1.coin_reject}, 0);
    rst = 1'b1;
    idle();
    drive(2'b01, 2'b00, 1'b0);
    chk("coin0_first", i1.credit, 2);
    chk("session_on", i1.session_active, 1);
    repeat (4) @(posedge clk);
    #1;
    chk("coin0_held", i1.credit, 2);
    idle();
    drive(2'b01, 2'b00, 1'b0);
    idle();
    drive(2'b01, 2'b00, 1'b0);
    chk("coin0_x3", i1.credit, 6);
    idle();
    drive(2'b10, 2'b00, 1'b0);
    chk("coin1_26", i1.credit, 26);
    idle();
    drive(2'b01, 2'b00, 1'b0);
    chk("credit_28", i1.credit, 28);
    idle();
    drive(2'b10, 2'b00, 1'b0);
    chk("over_reject", i1.coin_reject, 2'b10);
    chk("over_credit", i1.credit, 28);
    idle();
    chk("reject_1cyc", i1.coin_reject, 0);
    drive(2'b01, 2'b00, 1'b0);
    chk("exact_max", i1.credit, 30);
    chk("exact_max_rej", i1.coin_reject, 0);
    idle();
    drive(2'b01, 2'b00, 1'b0);
    chk("above_max_rej", i1.coin_reject, 2'b01);
    chk("above_max_cr", i1.credit, 30);
    idle();
    drive(2'b00, 2'b10, 1'b0);
    chk("buy1_a", i1.credit, 20);
    idle();
    drive(2'b00, 2'b10, 1'b0);
    idle();
    drive(2'b01, 2'b00, 1'b0);
    chk("credit_12", i1.credit, 12);
    idle();
    drive(2'b00, 2'b10, 1'b0);
    chk("buy1_ack", i1.vend_ack, 2'b10);
    chk("buy1_credit", i1.credit, 2);
    idle();
    chk("ack_1cyc", i1.vend_ack, 0);
    drive(2'b00, 2'b01, 1'b0);
    chk("buy0_nack", i1.vend_nack, 2'b01);
    chk("buy0_ack0", i1.vend_ack, 0);
    chk("buy0_credit", i1.credit, 2);
    idle();
    drive(2'b10, 2'b01, 1'b0);
    chk("mix_nack", i1.vend_nack, 2'b01);
    chk("mix_credit22", i1.credit, 22);
    idle();
    drive(2'b01, 2'b01, 1'b0);
    chk("both_ack", i1.vend_ack, 2'b01);
    chk("both_credit", i1.credit, 19);
    idle();
    drive(2'b00, 2'b11, 1'b0);
    chk("dual_buy_ack", i1.vend_ack, 2'b01);
    chk("dual_buy_nack", i1.vend_nack, 2'b10);
    chk("dual_buy_cr", i1.credit, 14);
    idle();
    drive(2'b11, 2'b00, 1'b0);
    chk("dual_coin_rej", i1.coin_reject, 2'b10);
    chk("dual_coin_cr", i1.credit, 16);
    idle();
    drive(2'b01, 2'b00, 1'b0);
    idle();
    drive(2'b01, 2'b00, 1'b0);
    idle();
    drive(2'b01, 2'b00, 1'b0);
    chk("credit_22", i1.credit, 22);
    idle();
    drive(2'b01, 2'b00, 1'b1);
    chk("cancel_coin_rej", i1.coin_reject, 2'b01);
    chk("cancel_credit0", i1.credit, 0);
    chk("cancel_session", i1.session_active, 0);
`ifdef CHANGE_DISPENSE_EN
    chk("disp_first_val", i1.change_value, 22);
    n = 0;
    repeat (30) begin
      idle();
      n += int'(i1.change_valid);
    end
    chk("disp_pulses", n, 22);
    chk("disp_end_val", i1.change_value, 0);
`else
    chk("refund_valid", i1.change_valid, 1);
    chk("refund_value", i1.change_value, 22);
    idle();
    chk("refund_valid_off", i1.change_valid, 0);
    chk("refund_value_clr", i1.change_value, 0);
`endif
    chk("after_ref_credit", i1.credit, 0);
    chk("after_ref_session", i1.session_active, 0);
    drive(2'b00, 2'b00, 1'b1);
    chk("idle_cancel_ign", i1.change_valid, 0);
    idle();
    drive(2'b10, 2'b00, 1'b0);
    chk("credit_20", i1.credit, 20);
    idle();
    i1.accept_en = 1'b0;
    #1;
    chk("dis_session", i1.session_active, 0);
    drive(2'b01, 2'b00, 1'b0);
    chk("dis_coin_rej", i1.coin_reject, 2'b01);
    chk("dis_coin_cr", i1.credit, 20);
    idle();
    drive(2'b00, 2'b01, 1'b0);
    chk("dis_buy_nack", i1.vend_nack, 2'b01);
    chk("dis_buy_cr", i1.credit, 20);
    idle();
    i1.accept_en = 1'b1;
    drive(2'b00, 2'b00, 1'b1);
`ifdef CHANGE_DISPENSE_EN
    chk("midref_val", i1.change_value, 20);
    idle();
    chk("midref_pulse", i1.change_valid, 1);
`else
    chk("midref_valid", i1.change_valid, 1);
`endif
    i1.cancel = 1'b0;
    rst = 1'b0;
    #1;
    chk("midrst_valid", i1.change_valid, 0);
    chk("midrst_value", i1.change_value, 0);
    chk("midrst_credit", i1.credit, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    idle();
    chk("postrst_valid", i1.change_valid, 0);
    chk("postrst_session", i1.session_active, 0);
    i2.coin_in = 2'b01;
    @(posedge clk);
    #1;
    i2.coin_in = 2'b00;
    @(posedge clk);
    #1;
    i2.coin_in = 2'b01;
    @(posedge clk);
    #1;
    i2.coin_in = 2'b00;
    chk("to_credit4", i2.credit, 4);
    repeat (98) @(posedge clk);
    #1;
    chk("to_99_hold", i2.credit, 4);
    i2.buy_req = 2'b01;
    @(posedge clk);
    #1;
    i2.buy_req = 2'b00;
    chk("to_evt_nack", i2.vend_nack, 2'b01);
    repeat (99) @(posedge clk);
    #1;
    chk("to_restart_cr", i2.credit, 4);
    chk("to_restart_ses", i2.session_active, 1);
    @(posedge clk);
    #1;
    chk("to_last_idle", i2.credit, 4);
    @(posedge clk);
    #1;
    chk("to_fire_credit", i2.credit, 0);
    chk("to_fire_session", i2.session_active, 0);
`ifdef CHANGE_DISPENSE_EN
    chk("to_fire_value", i2.change_value, 4);
`else
    chk("to_fire_valid", i2.change_valid, 1);
    chk("to_fire_value", i2.change_value, 4);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
